// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
package pll_reconfig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWD,
        ST_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_LOCKED
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b01;
    localparam logic [1:0] ERR_LOCK_LOST = 2'b10;
    localparam logic [1:0] ERR_BAD_CFG   = 2'b11;

    localparam logic [9:0]  DYN_ODIV_RST  = 10'd100;
    localparam logic [9:0]  DYN_DUTY_RST  = 10'd100;
    localparam logic [12:0] DYN_PHASE_RST = 13'd16;

    // Zero divider, or duty beyond twice the divider, cannot be programmed.
    function automatic logic cfg_is_bad(input logic [9:0] odiv, input logic [9:0] duty);
        return (odiv == '0) || ({1'b0, duty} > {odiv, 1'b0});
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterized two-flop synchronizer with async active-low clear.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL bring-up / reconfiguration sequencer: power-down, reset, lock wait,
// lock qualification and lock-loss supervision.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned PWD_CYCLES   = 10,
    parameter int unsigned RST_CYCLES   = 10,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_STABLE  = 16
) (
    input  logic        clk_tb,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [9:0]  cfg_odiv,
    input  logic [9:0]  cfg_duty,
    input  logic [12:0] cfg_phase,
    input  logic        pll_lock,
    output logic        pll_pwd,
    output logic        pll_rst,
    output logic [9:0]  dyn_odiv0,
    output logic [9:0]  dyn_duty0,
    output logic [12:0] dyn_phase0,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  lock_loss_cnt
);

    localparam logic [15:0] C_PWD_LAST = 16'(PWD_CYCLES - 1);
    localparam logic [15:0] C_RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] C_TO_LAST  = 16'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that saw lock already counts as the first stable cycle.
    localparam logic [15:0] C_STB_LAST = 16'((LOCK_STABLE > 1) ? (LOCK_STABLE - 2) : 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_lock_s;
    logic        w_xfer;
    logic        w_bad;
    logic        w_load;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic [1:0]  w_code_nxt;
    logic        w_loss_inc;

    logic        r_pwd, r_rst, r_busy, r_done, r_err;
    logic [1:0]  r_err_code;
    logic [7:0]  r_loss;
    logic [9:0]  r_odiv, r_duty;
    logic [12:0] r_phase;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk_tb),
        .rst_n (rst_n),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    assign cfg_ready = (r_state == ST_IDLE) || (r_state == ST_LOCKED);
    assign w_xfer    = cfg_valid && cfg_ready;
    assign w_bad     = cfg_is_bad(cfg_odiv, cfg_duty);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_code_nxt  = r_err_code;
        w_loss_inc  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_xfer && !w_bad) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_PWD;
                end else if (w_xfer) begin
                    w_err_nxt  = 1'b1;
                    w_code_nxt = ERR_BAD_CFG;
                end else begin
                    w_state_nxt = ST_RST;
                end
            end
            ST_PWD: begin
                if (r_cnt == C_PWD_LAST) w_state_nxt = ST_RST;
            end
            ST_RST: begin
                if (r_cnt == C_RST_LAST) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    if (LOCK_STABLE <= 1) begin
                        w_state_nxt = ST_LOCKED;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_STABLE;
                    end
                end else if (r_cnt == C_TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = ERR_TIMEOUT;
                    w_state_nxt = ST_PWD;
                end
            end
            ST_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_cnt == C_STB_LAST) begin
                    w_state_nxt = ST_LOCKED;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_LOCKED: begin
                // A good transfer outranks a simultaneous lock loss.
                if (w_xfer && !w_bad) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_PWD;
                end else if (!w_lock_s) begin
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = ERR_LOCK_LOST;
                    w_loss_inc  = 1'b1;
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (w_xfer) begin
                    w_err_nxt  = 1'b1;
                    w_code_nxt = ERR_BAD_CFG;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_cnt_nxt = (w_state_nxt != r_state) ? '0 : r_cnt + 16'd1;
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pwd      <= 1'b0;
            r_rst      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_loss     <= '0;
            r_odiv     <= DYN_ODIV_RST;
            r_duty     <= DYN_DUTY_RST;
            r_phase    <= DYN_PHASE_RST;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pwd      <= (w_state_nxt == ST_PWD);
            r_rst      <= (w_state_nxt == ST_RST) || (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_LOCKED);
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_code_nxt;
            if (w_loss_inc && (r_loss != 8'hFF)) r_loss <= r_loss + 8'd1;
            if (w_load) begin
                r_odiv  <= cfg_odiv;
                r_duty  <= cfg_duty;
                r_phase <= cfg_phase;
            end
        end
    end

    assign pll_pwd       = r_pwd;
    assign pll_rst       = r_rst;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign err_code      = r_err_code;
    assign lock_loss_cnt = r_loss;
    assign dyn_odiv0     = r_odiv;
    assign dyn_duty0     = r_duty;
    assign dyn_phase0    = r_phase;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq: cfg vector table, err scoreboard
// queue, and hand sequences for lock timing, timeout, lock loss and reset.
module tb_pll_reconfig_seq;
    import pll_reconfig_pkg::*;

    localparam int unsigned TO = 250;

    logic        clk_tb = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [9:0]  cfg_odiv = '0;
    logic [9:0]  cfg_duty = '0;
    logic [12:0] cfg_phase = '0;
    logic        pll_lock = 1'b0;
    logic        cfg_ready, pll_pwd, pll_rst, busy, done, err;
    logic [9:0]  dyn_odiv0, dyn_duty0;
    logic [12:0] dyn_phase0;
    logic [1:0]  err_code;
    logic [7:0]  lock_loss_cnt;

    always #5 clk_tb = ~clk_tb;

    pll_reconfig_seq #(
        .PWD_CYCLES   (10),
        .RST_CYCLES   (10),
        .LOCK_TIMEOUT (TO),
        .LOCK_STABLE  (16)
    ) dut (
        .clk_tb        (clk_tb),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_odiv      (cfg_odiv),
        .cfg_duty      (cfg_duty),
        .cfg_phase     (cfg_phase),
        .pll_lock      (pll_lock),
        .pll_pwd       (pll_pwd),
        .pll_rst       (pll_rst),
        .dyn_odiv0     (dyn_odiv0),
        .dyn_duty0     (dyn_duty0),
        .dyn_phase0    (dyn_phase0),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_code      (err_code),
        .lock_loss_cnt (lock_loss_cnt)
    );

    typedef struct {
        logic [9:0]  odiv;
        logic [9:0]  duty;
        logic [12:0] phase;
        logic        bad;
    } vec_t;

    int          n_total = 0;
    int          n_bad = 0;
    logic [1:0]  exp_err[$];
    logic [9:0]  e_odiv = 10'd100;
    logic [9:0]  e_duty = 10'd100;
    logic [12:0] e_phase = 13'd16;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // err scoreboard: every err pulse must match the oldest expected code.
    always @(negedge clk_tb) begin
        if (rst_n && err) begin
            if (exp_err.size() == 0) begin
                check("err_unexpected", 32'(exp_err.size()), 32'd1);
            end else begin
                check("err_code", 32'(err_code), 32'(exp_err.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic count_phase(output int np, output int nr);
        np = 0;
        nr = 0;
        while (pll_pwd && np < 1000) begin np++; tick(); end
        while (pll_rst && nr < 1000) begin nr++; tick(); end
    endtask

    task automatic relock(input string name);
        int n;
        pll_lock = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!done && n < 2000);
        check(name, 32'(n), 32'd18);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic xfer(input vec_t v);
        cfg_odiv  = v.odiv;
        cfg_duty  = v.duty;
        cfg_phase = v.phase;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        if (!v.bad) begin
            e_odiv  = v.odiv;
            e_duty  = v.duty;
            e_phase = v.phase;
        end
    endtask

    task automatic check_dyn(input string name);
        check({name, "_odiv"}, 32'(dyn_odiv0), 32'(e_odiv));
        check({name, "_duty"}, 32'(dyn_duty0), 32'(e_duty));
        check({name, "_phase"}, 32'(dyn_phase0), 32'(e_phase));
    endtask

    task automatic check_reset_vals(input string name);
        e_odiv  = 10'd100;
        e_duty  = 10'd100;
        e_phase = 13'd16;
        check({name, "_pwd"}, 32'(pll_pwd), 32'd0);
        check({name, "_rst"}, 32'(pll_rst), 32'd1);
        check_dyn(name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_code"}, 32'(err_code), 32'd0);
        check({name, "_loss"}, 32'(lock_loss_cnt), 32'd0);
        check({name, "_ready"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[6];
        int np, nr, n;
        vecs[0] = '{10'd200,  10'd200,  13'd16,   1'b0};
        vecs[1] = '{10'd0,    10'd0,    13'd5,    1'b1};
        vecs[2] = '{10'd50,   10'd101,  13'd7,    1'b1};
        vecs[3] = '{10'd50,   10'd100,  13'd7,    1'b0};
        vecs[4] = '{10'd1,    10'd3,    13'd0,    1'b1};
        vecs[5] = '{10'd1023, 10'd1023, 13'd8191, 1'b0};

        #1 rst_n = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");

        // Bring-up without any cfg transfer, lock arriving 200 cycles later.
        rst_n = 1'b1;
        tick();
        count_phase(np, nr);
        check("boot_pwd", 32'(np), 32'd0);
        check("boot_rst", 32'(nr), 32'd10);
        check("boot_busy", 32'(busy), 32'd1);
        check("boot_ready", 32'(cfg_ready), 32'd0);
        repeat (189) tick();
        check("boot_done_early", 32'(done), 32'd0);
        relock("boot_lock");
        tick();
        check("boot_done_pulse", 32'(done), 32'd0);

        for (int i = 0; i < 6; i++) begin
            check("vec_ready", 32'(cfg_ready), 32'd1);
            if (vecs[i].bad) exp_err.push_back(ERR_BAD_CFG);
            xfer(vecs[i]);
            check_dyn("vec_dyn");
            if (vecs[i].bad) begin
                check("vec_err", 32'(err), 32'd1);
                check("vec_bad_pwd", 32'(pll_pwd), 32'd0);
                check("vec_bad_busy", 32'(busy), 32'd0);
                tick();
                check("vec_err_pulse", 32'(err), 32'd0);
                check("vec_bad_rst", 32'(pll_rst), 32'd0);
            end else begin
                pll_lock = 1'b0;
                count_phase(np, nr);
                check("vec_pwd_len", 32'(np), 32'd10);
                check("vec_rst_len", 32'(nr), 32'd10);
                relock("vec_relock");
            end
        end

        // Lock falls at the same edge as a good transfer: transfer wins.
        pll_lock = 1'b0;
        tick();
        tick();
        xfer(vecs[3]);
        check("prio_pwd", 32'(pll_pwd), 32'd1);
        check("prio_loss", 32'(lock_loss_cnt), 32'd0);
        check("prio_err", 32'(err), 32'd0);
        count_phase(np, nr);
        relock("prio_relock");

        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            exp_err.push_back(ERR_LOCK_LOST);
            repeat (3) tick();
            check("loss_cnt", 32'(lock_loss_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            relock("loss_relock");
        end
        check("loss_queue", 32'(exp_err.size()), 32'd0);

        // Short glitch inside STABLE must restart the stability count.
        pll_lock = 1'b0;
        exp_err.push_back(ERR_LOCK_LOST);
        repeat (3) tick();
        pll_lock = 1'b1;
        repeat (8) tick();
        check("glitch_busy", 32'(busy), 32'd1);
        pll_lock = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("glitch_no_done", 32'(done), 32'd0);
        end
        relock("glitch_relock");
        check("glitch_loss_sat", 32'(lock_loss_cnt), 32'd255);

        // Lock never arrives: timeout error and full retry, twice.
        xfer('{10'd300, 10'd20, 13'd9, 1'b0});
        pll_lock = 1'b0;
        count_phase(np, nr);
        for (int r = 0; r < 2; r++) begin
            exp_err.push_back(ERR_TIMEOUT);
            n = 0;
            while (!err && n < 1000) begin tick(); n++; end
            check("to_cycles", 32'(n), 32'(TO));
            check("to_pwd", 32'(pll_pwd), 32'd1);
            count_phase(np, nr);
            check("to_pwd_len", 32'(np), 32'd10);
            check("to_rst_len", 32'(nr), 32'd10);
        end
        relock("to_relock");

        // Asynchronous reset in the middle of PWD.
        xfer('{10'd500, 10'd400, 13'd77, 1'b0});
        check_dyn("mid_dyn");
        repeat (3) tick();
        check("mid_in_pwd", 32'(pll_pwd), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        check("final_queue", 32'(exp_err.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
